// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the bimodal branch predictor: opcodes, counter states, FSM states.
// Latency: n/a (package).
// Backpressure: n/a (package).
package branch_predictor_pkg;

    // Conditional branch opcodes seen in IF
    localparam logic [5:0] OP_BLTZ_BGEZ = 6'b000001;
    localparam logic [5:0] OP_BEQ       = 6'b000100;
    localparam logic [5:0] OP_BNE       = 6'b000101;
    localparam logic [5:0] OP_BLEZ      = 6'b000110;
    localparam logic [5:0] OP_BGTZ      = 6'b000111;

    // 2-bit saturating counter states; bit 1 is the taken prediction
    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    typedef enum logic {
        BP_IDLE  = 1'b0,
        BP_CLEAR = 1'b1
    } bp_state_e;

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) ||
               (op == OP_BGTZ) || (op == OP_BLTZ_BGEZ);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating counter next-state function for one predictor entry.
// Latency: combinational.
// Backpressure: none.
// Ports: cur (present counter), taken (resolved outcome), nxt (counter after training).
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != BP_ST) nxt = cur + 2'd1;
        end else begin
            if (cur != BP_SNT) nxt = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: PC-indexed table of 2-bit counters, trained from ID, with clear sweep and perf counters.
// Latency: prediction and mispredict are combinational; training becomes visible the cycle after res_valid.
// Backpressure: none; updates arriving during a clear sweep are dropped (still counted).
// Ports: if_pc/if_op -> pred_taken lookup; res_* training and mispredict flag;
//        clear_req/busy sweep control; branch_cnt/miss_cnt saturating statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         IDX_W   = 6,
    parameter logic [1:0] INIT_ST = 2'b01,
    parameter int         CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    input  logic [5:0]       if_op,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic             res_taken,
    input  logic             res_pred,
    output logic             mispredict,
    input  logic             clear_req,
    output logic             busy,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]       bht_q [ENTRIES];
    bp_state_e        state_q;
    logic [IDX_W-1:0] ptr_q;

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       upd_nxt;

    // Word-aligned PCs: drop the byte offset, keep IDX_W bits, alias the rest
    assign lk_idx  = if_pc[IDX_W+1:2];
    assign upd_idx = res_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], res_pc[31:IDX_W+2], res_pc[1:0]};

    // Reads the registered table, so a same-cycle update to this index is not bypassed
    assign pred_taken = is_branch(if_op) & bht_q[lk_idx][1] & (state_q == BP_IDLE);
    assign mispredict = res_valid & (res_taken != res_pred);
    assign busy       = (state_q == BP_CLEAR);

    bp_sat_counter u_sat (
        .cur   (bht_q[upd_idx]),
        .taken (res_taken),
        .nxt   (upd_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BP_IDLE;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                BP_IDLE: begin
                    if (clear_req) begin
                        state_q <= BP_CLEAR;
                        ptr_q   <= '0;
                    end
                end
                BP_CLEAR: begin
                    ptr_q <= ptr_q + IDX_W'(1);
                    if (ptr_q == IDX_W'(ENTRIES - 1)) state_q <= BP_IDLE;
                end
                default: state_q <= BP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) bht_q[i] <= INIT_ST;
        end else if (state_q == BP_CLEAR) begin
            bht_q[ptr_q] <= INIT_ST;
        end else if (res_valid) begin
            bht_q[upd_idx] <= upd_nxt;
        end
    end

    // Statistics stick at all-ones rather than wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else begin
            if (res_valid && (branch_cnt != '1)) branch_cnt <= branch_cnt + CNT_W'(1);
            if (mispredict && (miss_cnt != '1))  miss_cnt   <= miss_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: abstract table model checked every cycle plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = '0;
    logic [5:0]  if_op = '0;
    logic        pred_taken;
    logic        res_valid = 1'b0;
    logic [31:0] res_pc = '0;
    logic        res_taken = 1'b0;
    logic        res_pred = 1'b0;
    logic        mispredict;
    logic        clear_req = 1'b0;
    logic        busy;
    logic [31:0] branch_cnt;
    logic [31:0] miss_cnt;

    localparam logic [5:0] T_BLTZ = 6'd1;
    localparam logic [5:0] T_BEQ  = 6'd4;
    localparam logic [5:0] T_BNE  = 6'd5;
    localparam logic [5:0] T_BLEZ = 6'd6;
    localparam logic [5:0] T_BGTZ = 6'd7;
    localparam logic [5:0] T_ADDI = 6'd8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk        (clk),
        .rst        (rst),
        .if_pc      (if_pc),
        .if_op      (if_op),
        .pred_taken (pred_taken),
        .res_valid  (res_valid),
        .res_pc     (res_pc),
        .res_taken  (res_taken),
        .res_pred   (res_pred),
        .mispredict (mispredict),
        .clear_req  (clear_req),
        .busy       (busy),
        .branch_cnt (branch_cnt),
        .miss_cnt   (miss_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_tbl [64];
    int m_sweep_left;
    int m_bc;
    int m_mc;

    function automatic bit m_is_branch(input logic [5:0] op);
        return op == T_BEQ || op == T_BNE || op == T_BLEZ || op == T_BGTZ || op == T_BLTZ;
    endfunction

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) m_tbl[i] = 1;
            m_sweep_left = 0;
            m_bc = 0;
            m_mc = 0;
        end else begin
            if (res_valid) m_bc = m_bc + 1;
            if (res_valid && res_taken != res_pred) m_mc = m_mc + 1;
            if (m_sweep_left > 0) begin
                m_sweep_left = m_sweep_left - 1;
            end else if (clear_req) begin
                // Whole table ends up at the init value; predictions are masked meanwhile
                m_sweep_left = 64;
                for (int i = 0; i < 64; i++) m_tbl[i] = 1;
            end else if (res_valid) begin
                if (res_taken) m_tbl[m_idx(res_pc)] = (m_tbl[m_idx(res_pc)] < 3) ? m_tbl[m_idx(res_pc)] + 1 : 3;
                else           m_tbl[m_idx(res_pc)] = (m_tbl[m_idx(res_pc)] > 0) ? m_tbl[m_idx(res_pc)] - 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_pred;
        logic exp_miss;
        exp_pred = m_is_branch(if_op) && m_tbl[m_idx(if_pc)] >= 2 && m_sweep_left == 0;
        exp_miss = res_valid && (res_taken != res_pred);
        chk("model_pred_taken", {31'd0, pred_taken}, {31'd0, exp_pred});
        chk("model_mispredict", {31'd0, mispredict}, {31'd0, exp_miss});
        chk("model_busy", {31'd0, busy}, {31'd0, m_sweep_left > 0});
        chk("model_branch_cnt", branch_cnt, m_bc);
        chk("model_miss_cnt", miss_cnt, m_mc);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic taken, input logic pred);
        res_valid = 1'b1;
        res_pc    = pc;
        res_taken = taken;
        res_pred  = pred;
        step();
        res_valid = 1'b0;
    endtask

    initial begin
        int n_busy;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        if_op = T_BEQ;
        if_pc = 32'h100;
        #1;
        chk("reset_pred", {31'd0, pred_taken}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_branch_cnt", branch_cnt, 32'd0);
        chk("reset_miss_cnt", miss_cnt, 32'd0);
        step();

        // Two back-to-back taken mispredicts at 0x100
        res_valid = 1'b1; res_pc = 32'h100; res_taken = 1'b1; res_pred = 1'b0;
        #1;
        chk("train1_mispredict", {31'd0, mispredict}, 32'd1);
        chk("train1_pred_no_bypass", {31'd0, pred_taken}, 32'd0);
        step();
        #1;
        chk("train2_mispredict", {31'd0, mispredict}, 32'd1);
        chk("train2_pred_after_first", {31'd0, pred_taken}, 32'd1);
        step();
        res_valid = 1'b0;
        #1;
        chk("train_pred_strong", {31'd0, pred_taken}, 32'd1);
        chk("train_branch_cnt", branch_cnt, 32'd2);
        chk("train_miss_cnt", miss_cnt, 32'd2);

        // Saturation at 0x104
        if_pc = 32'h104;
        resolve(32'h104, 1'b1, 1'b1);
        resolve(32'h104, 1'b1, 1'b1);
        resolve(32'h104, 1'b1, 1'b1);
        resolve(32'h104, 1'b0, 1'b1);
        #1;
        chk("sat_one_nt_pred", {31'd0, pred_taken}, 32'd1);
        resolve(32'h104, 1'b0, 1'b1);
        #1;
        chk("sat_two_nt_pred", {31'd0, pred_taken}, 32'd0);
        chk("sat_branch_cnt", branch_cnt, 32'd7);
        chk("sat_miss_cnt", miss_cnt, 32'd4);

        // Aliasing and opcode filtering
        if_pc = 32'h200; if_op = T_BNE;
        #1;
        chk("alias_bne_pred", {31'd0, pred_taken}, 32'd1);
        if_op = T_ADDI;
        #1;
        chk("alias_addi_pred", {31'd0, pred_taken}, 32'd0);
        if_op = T_BLTZ;
        #1;
        chk("alias_bltz_pred", {31'd0, pred_taken}, 32'd1);
        step();

        // Clear sweep
        resolve(32'h108, 1'b1, 1'b0);
        resolve(32'h108, 1'b1, 1'b0);
        if_op = T_BEQ; if_pc = 32'h108;
        #1;
        chk("pre_clear_pred", {31'd0, pred_taken}, 32'd1);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        n_busy = 0;
        while (busy && n_busy < 200) begin
            n_busy++;
            if (n_busy == 10) begin
                res_valid = 1'b1; res_pc = 32'h100; res_taken = 1'b1; res_pred = 1'b1;
                clear_req = 1'b1;
            end else begin
                res_valid = 1'b0;
                clear_req = 1'b0;
            end
            if_pc = 32'h100;
            step();
        end
        res_valid = 1'b0;
        clear_req = 1'b0;
        chk("clear_busy_cycles", n_busy, 32'd64);
        chk("clear_branch_cnt", branch_cnt, 32'd10);
        for (int i = 0; i < 64; i++) begin
            if_pc = 32'(i * 4);
            #1;
            chk("post_clear_pred", {31'd0, pred_taken}, 32'd0);
            step();
        end

        // Reset in the middle of a sweep
        resolve(32'h100, 1'b1, 1'b0);
        resolve(32'h100, 1'b1, 1'b0);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (20) step();
        chk("midsweep_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        if_pc = 32'h100;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_branch_cnt", branch_cnt, 32'd0);
        chk("abort_miss_cnt", miss_cnt, 32'd0);
        step();
        rst = 1'b0;
        step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("reclear_busy", {31'd0, busy}, 32'd1);
        n_busy = 0;
        while (busy && n_busy < 200) begin
            n_busy++;
            step();
        end
        chk("reclear_busy_cycles", n_busy, 32'd64);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the IF stage, built from a bimodal table of 2-bit saturating counters indexed by PC.
- Drives predict_signal into the next-PC mux for conditional branch opcodes (BEQ, BNE, BLEZ, BGTZ, BLTZ_BGEZ).
- Trains on branch outcomes resolved in ID and flags mispredictions so the pipeline can redirect and flush.
- Includes a table-clear sweep FSM and saturating performance counters.

Parameters:
- IDX_W, 6, table index width; table has 2**IDX_W entries, index = PC[IDX_W+1:2].
- INIT_ST, 2'b01, counter value loaded at reset and by the clear sweep (weakly not-taken).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  32  PC of the instruction in IF.
- if_op  in  6  opcode of the instruction in IF.
- pred_taken  out  1  prediction for the IF instruction; feeds predict_signal.
- res_valid  in  1  a conditional branch resolved in ID this cycle.
- res_pc  in  32  PC of the resolved branch.
- res_taken  in  1  actual outcome.
- res_pred  in  1  prediction that was made for it, carried down the pipeline.
- mispredict  out  1  res_valid & (res_taken != res_pred).
- clear_req  in  1  request to reinitialise the whole table.
- busy  out  1  clear sweep in progress.
- branch_cnt  out  CNT_W  number of resolved branches.
- miss_cnt  out  CNT_W  number of mispredictions.

Behaviour:
- Reset (async, active-high):
  - All entries go to INIT_ST.
  - FSM goes to IDLE, sweep pointer to 0.
  - branch_cnt and miss_cnt go to 0.
  - busy, pred_taken and mispredict go to 0, since res_valid is expected low in reset.
- Lookup (combinational from registered table, zero latency): pred_taken = is_branch(if_op) & table[if_pc[IDX_W+1:2]][1] & (state==IDLE). Non-branch opcodes always give 0.
- mispredict is combinational and valid in the same cycle as res_valid. It is not gated by the FSM.
- Update (at posedge, IDLE only, when res_valid):
  - Entry at index res_pc[IDX_W+1:2] is updated.
  - Taken: increment, saturating at 2'b11.
  - Not taken: decrement, saturating at 2'b00.
  - Transitions: 00->01->10->11 on taken; reverse on not-taken; 11 stays 11 on taken; 00 stays 00 on not-taken.
- Same-cycle lookup and update of the same index: lookup returns the pre-update value (no bypass). The new value is visible the next cycle.
- FSM:
  - IDLE: clear_req=1 -> CLEAR, pointer=0, busy=1 from the next cycle.
  - CLEAR: each cycle writes INIT_ST at the pointer and increments it.
  - After writing entry 2**IDX_W-1 -> IDLE, busy=0. The sweep takes exactly 2**IDX_W cycles.
  - While in CLEAR, res_valid updates are dropped (table unchanged beyond the sweep), pred_taken=0, and clear_req is ignored.
  - A rst assertion mid-sweep aborts it immediately: table is fully INIT_ST and state is IDLE.
- Counters (CNT_W bits, saturate at all-ones, never wrap):
  - branch_cnt increments on every res_valid cycle, including during CLEAR.
  - miss_cnt increments when mispredict=1.
- PC bits [1:0] and bits above IDX_W+1 are ignored, so aliasing is permitted.

Decomposition:
- Shared package (ctrl_encode_def.v):
  - Branch opcode defines, already present.
  - New defines BP_SNT=2'b00, BP_WNT=2'b01, BP_WT=2'b10, BP_ST=2'b11.
  - FSM encodings BP_IDLE, BP_CLEAR.
- Sub-module bp_sat_counter: combinational 2-bit next-state function (cur, taken -> nxt), instantiated once on the update path.

Test Plan:
- Reset, then if_op=BEQ, if_pc=0x100 -> pred_taken=0 (entry=01); busy=0, branch_cnt=miss_cnt=0.
- Resolve pc=0x100 taken with res_pred=0, twice on consecutive cycles -> mispredict=1 both cycles; entry 01->10->11; lookup of 0x100 gives pred_taken=1 from the cycle after the first update; miss_cnt=2, branch_cnt=2.
- Saturation: 3 taken updates at pc=0x104 -> entry stays 11; then 1 not-taken -> 10 and pred_taken stays 1; a second not-taken -> 01 and pred_taken=0.
- Aliasing and non-branch opcodes: with IDX_W=6, train pc=0x100 to 11; lookup pc=0x200 (same index) with op=BNE -> pred_taken=1; same pc with op=ADDI (R-type/other) -> 0.
- Clear: train several entries, pulse clear_req -> busy=1 for exactly 64 cycles; pred_taken=0 throughout; a res_valid during the sweep increments branch_cnt but leaves the table unchanged; afterwards all lookups equal INIT_ST (pred 0).
- Assert rst at sweep cycle 20 -> busy=0 immediately, counters=0, all entries=01, FSM accepts a new clear_req next cycle.
